// File: rtl/tap_report_tx.sv
// tap_report_tx: samples a status value on request and sends it as "T=<hex>\r\n" in 8N1 UART framing.
module tap_report_tx #(
    parameter int CLOCKFRQ    = 32000000,
    parameter int BAUDRATE    = 1000000,
    parameter int VALUE_WIDTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   report_i,
    input  logic [VALUE_WIDTH-1:0] value_i,
    output logic                   tx_o,
    output logic                   busy_o,
    output logic                   done_o
);
    localparam int DIVISOR = CLOCKFRQ / BAUDRATE;
    localparam int NDIG    = (VALUE_WIDTH + 3) / 4;
    localparam int NBYTES  = NDIG + 4;
    localparam int BW      = $clog2(DIVISOR);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                 state_q, state_d;
    logic [BW-1:0]          baud_q, baud_d;
    logic [2:0]             bit_q, bit_d;
    logic [4:0]             byte_q, byte_d;
    logic [VALUE_WIDTH-1:0] snap_q, snap_d;
    logic                   pend_q, pend_d;
    logic                   tx_q, tx_d;
    logic                   baud_end, last_byte;
    logic [7:0]             cur_byte;

    function automatic logic [7:0] msg_byte(input logic [4:0] idx, input logic [VALUE_WIDTH-1:0] v);
        logic [NDIG*4-1:0] pad;
        logic [3:0]        nib;
        int                sh;
        pad = (NDIG*4)'(v);
        sh  = (int'(idx) >= 2 && int'(idx) < NDIG + 2) ? 4 * (NDIG + 1 - int'(idx)) : 0;
        nib = 4'(pad >> sh);
        return idx == 5'd0 ? 8'h54 :
               idx == 5'd1 ? 8'h3D :
               int'(idx) < NDIG + 2 ? 8'(nib) + (nib < 4'd10 ? 8'h30 : 8'h37) :
               int'(idx) == NDIG + 2 ? 8'h0D : 8'h0A;
    endfunction

    assign baud_end  = baud_q == BW'(DIVISOR - 1);
    assign last_byte = byte_q == 5'(NBYTES - 1);
    assign busy_o    = state_q != IDLE;
    assign done_o    = state_q == STOP && baud_end && last_byte;
    assign tx_o      = tx_q;

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        snap_d   = snap_q;
        pend_d   = pend_q;
        if (state_q != IDLE) begin
            baud_d = baud_end ? '0 : baud_q + 1'b1;
            pend_d = pend_q | report_i;
        end
        case (state_q)
            IDLE: if (report_i) begin
                state_d = START;
                snap_d  = value_i;
                byte_d  = '0;
            end
            START: if (baud_end) begin
                state_d = DATA;
                bit_d   = '0;
            end
            DATA: if (baud_end) begin
                bit_d   = bit_q + 1'b1;
                state_d = bit_q == 3'd7 ? STOP : DATA;
            end
            STOP: if (baud_end) begin
                // A request seen on the completing edge counts as pending too.
                if (!last_byte) begin
                    byte_d  = byte_q + 1'b1;
                    state_d = START;
                end else begin
                    state_d = (pend_q || report_i) ? START : IDLE;
                    snap_d  = (pend_q || report_i) ? value_i : snap_q;
                    byte_d  = '0;
                    pend_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        cur_byte = msg_byte(byte_d, snap_d);
        tx_d     = state_d == START ? 1'b0 : state_d == DATA ? cur_byte[bit_d] : 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            snap_q  <= '0;
            pend_q  <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            snap_q  <= snap_d;
            pend_q  <= pend_d;
            tx_q    <= tx_d;
        end
    end
endmodule

// File: tb/tb_tap_report_tx.sv
// tb_tap_report_tx: directed vectors and multi-cycle sequences for tap_report_tx across four parameter sets.
module tb_tap_report_tx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [3:0]  rep, tx, busy, done;
    logic [7:0]  v8, v2;
    logic [4:0]  v5;
    logic [11:0] v12;
    int ntests = 0;
    int nfail  = 0;

    tap_report_tx u8 (.clk_i(clk), .rst_ni(rst_n), .report_i(rep[0]), .value_i(v8),
                      .tx_o(tx[0]), .busy_o(busy[0]), .done_o(done[0]));
    tap_report_tx #(.VALUE_WIDTH(5)) u5 (.clk_i(clk), .rst_ni(rst_n), .report_i(rep[1]), .value_i(v5),
                      .tx_o(tx[1]), .busy_o(busy[1]), .done_o(done[1]));
    tap_report_tx #(.VALUE_WIDTH(12)) u12 (.clk_i(clk), .rst_ni(rst_n), .report_i(rep[2]), .value_i(v12),
                      .tx_o(tx[2]), .busy_o(busy[2]), .done_o(done[2]));
    tap_report_tx #(.CLOCKFRQ(4), .BAUDRATE(2)) u2 (.clk_i(clk), .rst_ni(rst_n), .report_i(rep[3]), .value_i(v2),
                      .tx_o(tx[3]), .busy_o(busy[3]), .done_o(done[3]));

    typedef struct {
        int          sel;
        logic [11:0] value;
        int          nb;
        logic [63:0] msg;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_value(input int sel, input logic [11:0] v);
        case (sel)
            0: v8 = v[7:0];
            1: v5 = v[4:0];
            2: v12 = v;
            default: v2 = v[7:0];
        endcase
    endtask

    // Called at the negedge of the first message cycle; checks every cycle of the frame.
    task automatic run_msg(input int sel, input logic [63:0] msg, input int nb, input int hold_until,
                           input int p0, input int p1, input int p2, input int vc,
                           input logic [11:0] vnew, input string nm);
        int d, total, byt, bp, busy_err, done_err;
        int bad [8];
        logic eb;
        logic [7:0] b;
        d = (sel == 3) ? 2 : 32;
        total = nb * 10 * d;
        busy_err = 0;
        done_err = 0;
        foreach (bad[k]) bad[k] = 0;
        for (int c = 0; c < total; c++) begin
            byt = c / (10 * d);
            bp  = (c / d) % 10;
            b   = msg[63-8*byt -: 8];
            eb  = bp == 0 ? 1'b0 : bp == 9 ? 1'b1 : b[bp-1];
            if (tx[sel] !== eb) bad[byt]++;
            if (busy[sel] !== 1'b1) busy_err++;
            if (done[sel] !== 1'(c == total - 1)) done_err++;
            rep[sel] = (c < hold_until) || c == p0 || c == p1 || c == p2;
            if (c == vc) set_value(sel, vnew);
            @(negedge clk);
        end
        for (int k = 0; k < nb; k++) chk($sformatf("%s byte%0d bad cycles", nm, k), bad[k], 0);
        chk($sformatf("%s busy low cycles", nm), busy_err, 0);
        chk($sformatf("%s done wrong cycles", nm), done_err, 0);
    endtask

    task automatic pulse(input int sel);
        rep[sel] = 1'b1;
        @(negedge clk);
        rep[sel] = 1'b0;
    endtask

    initial begin
        int cnt;
        vecs[0] = '{0, 12'h02A, 6, 64'h543D_3241_0D0A_0000};
        vecs[1] = '{0, 12'h000, 6, 64'h543D_3030_0D0A_0000};
        vecs[2] = '{0, 12'h0FF, 6, 64'h543D_4646_0D0A_0000};
        vecs[3] = '{0, 12'h09C, 6, 64'h543D_3943_0D0A_0000};
        vecs[4] = '{1, 12'h01F, 6, 64'h543D_3146_0D0A_0000};
        vecs[5] = '{1, 12'h010, 6, 64'h543D_3130_0D0A_0000};
        vecs[6] = '{2, 12'h0B0, 7, 64'h543D_3042_300D_0A00};
        vecs[7] = '{2, 12'hFE1, 7, 64'h543D_4645_310D_0A00};
        vecs[8] = '{3, 12'h0A5, 6, 64'h543D_4135_0D0A_0000};

        rst_n = 1'b0;
        rep = '0;
        v8 = '0; v5 = '0; v12 = '0; v2 = '0;
        repeat (3) @(negedge clk);
        chk("reset tx", tx, 4'hF);
        chk("reset busy", busy, 4'h0);
        chk("reset done", done, 4'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            set_value(vecs[i].sel, vecs[i].value);
            pulse(vecs[i].sel);
            run_msg(vecs[i].sel, vecs[i].msg, vecs[i].nb, 0, -1, -1, -1, -1, 12'h0, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d idle busy", i), busy[vecs[i].sel], 1'b0);
            chk($sformatf("vec%0d idle tx", i), tx[vecs[i].sel], 1'b1);
        end

        // Value change mid-message must not leak into the frame.
        v8 = 8'h2A;
        pulse(0);
        run_msg(0, 64'h543D_3241_0D0A_0000, 6, 0, -1, -1, -1, 100, 12'h007, "vchg");
        cnt = 0;
        repeat (100) begin
            if (busy[0] !== 1'b0 || tx[0] !== 1'b1) cnt++;
            @(negedge clk);
        end
        chk("vchg no second message", cnt, 0);

        // Three requests during a message coalesce into one back-to-back follow-up.
        v8 = 8'h2A;
        pulse(0);
        run_msg(0, 64'h543D_3241_0D0A_0000, 6, 0, 50, 300, 900, 1000, 12'h007, "pend1");
        run_msg(0, 64'h543D_3037_0D0A_0000, 6, 0, -1, -1, -1, -1, 12'h0, "pend2");
        chk("pend idle after follow-up", busy[0], 1'b0);

        // Reset in the middle of a data bit.
        v8 = 8'h2A;
        pulse(0);
        cnt = 0;
        for (int c = 0; c < 450; c++) begin
            if (done[0] !== 1'b0 || busy[0] !== 1'b1) cnt++;
            @(negedge clk);
        end
        chk("rst partial done/busy", cnt, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst mid tx", tx[0], 1'b1);
        chk("rst mid busy", busy[0], 1'b0);
        chk("rst mid done", done[0], 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        pulse(0);
        run_msg(0, 64'h543D_3241_0D0A_0000, 6, 0, -1, -1, -1, -1, 12'h0, "after_rst");

        // Report held high at DIVISOR=2: three contiguous frames.
        v2 = 8'h3C;
        rep[3] = 1'b1;
        @(negedge clk);
        run_msg(3, 64'h543D_3343_0D0A_0000, 6, 120, -1, -1, -1, -1, 12'h0, "hold1");
        run_msg(3, 64'h543D_3343_0D0A_0000, 6, 119, -1, -1, -1, -1, 12'h0, "hold2");
        run_msg(3, 64'h543D_3343_0D0A_0000, 6, 0, -1, -1, -1, -1, 12'h0, "hold3");
        chk("hold idle after three", busy[3], 1'b0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
